// File: rtl/mini_logger_dump_ctrl.sv
// Chronological dump sequencer for a mini_logger ring buffer: freezes logging, walks every
// valid line oldest-first one read word at a time, and streams the words over valid/ready.
module mini_logger_dump_ctrl #(
  parameter int MEM_DEPTH_LOG2 = 8,
  parameter int LINE_BYTES     = 24,
  parameter int OUTPUT_W       = 64,
  parameter int MEM_ADDR_W     = $clog2(LINE_BYTES * (2 ** MEM_DEPTH_LOG2))
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  log_en,
  output logic                  logging_active,
  input  logic                  dump_start,
  input  logic                  dump_abort,
  output logic                  busy,
  output logic                  dump_done,
  input  logic [MEM_ADDR_W-1:0] curr_wr_addr,
  input  logic                  has_looped,
  output logic                  rd_req_val,
  output logic [MEM_ADDR_W-1:0] rd_req_addr,
  input  logic                  rd_resp_val,
  input  logic [OUTPUT_W-1:0]   rd_resp_data,
  output logic                  out_val,
  output logic [OUTPUT_W-1:0]   out_data,
  output logic                  out_last,
  input  logic                  out_rdy
);

  localparam int LINE_ADDR_W  = MEM_DEPTH_LOG2;
  localparam int BLOCK_ADDR_W = $clog2(LINE_BYTES);
  localparam int SECTIONS     = LINE_BYTES * 8 / OUTPUT_W;
  localparam int SECTIONS_W   = $clog2(SECTIONS);
  localparam int ZERO_W       = BLOCK_ADDR_W - SECTIONS_W;
  localparam int CNT_W        = LINE_ADDR_W + 1;

  localparam logic [SECTIONS_W-1:0] SEC_LAST = SECTIONS_W'(SECTIONS - 1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(2 ** LINE_ADDR_W);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [LINE_ADDR_W-1:0]  cur_line_q, cur_line_d;
  logic [SECTIONS_W-1:0]   sec_q, sec_d;
  logic [CNT_W-1:0]        remain_q, remain_d;
  logic [OUTPUT_W-1:0]     hold_q, hold_d;
  logic                    abort_pend_q, abort_pend_d;
  logic                    dump_done_q, dump_done_d;

  logic [LINE_ADDR_W-1:0]  wr_line_s;
  logic [LINE_ADDR_W-1:0]  start_line_s;
  logic [CNT_W-1:0]        line_cnt_s;
  logic                    last_word_s;
  logic                    unused_addr_bits_s;

  // Snapshot of the logger write position taken at the moment a dump is accepted
  assign wr_line_s          = curr_wr_addr[MEM_ADDR_W-1 -: LINE_ADDR_W];
  assign start_line_s       = has_looped ? wr_line_s : '0;
  assign line_cnt_s         = has_looped ? CNT_FULL : {1'b0, wr_line_s};
  assign unused_addr_bits_s = ^curr_wr_addr[BLOCK_ADDR_W-1:0];
  assign last_word_s        = (sec_q == SEC_LAST) && (remain_q == CNT_ONE);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_line_q   <= '0;
      sec_q        <= '0;
      remain_q     <= '0;
      hold_q       <= '0;
      abort_pend_q <= 1'b0;
      dump_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_line_q   <= cur_line_d;
      sec_q        <= sec_d;
      remain_q     <= remain_d;
      hold_q       <= hold_d;
      abort_pend_q <= abort_pend_d;
      dump_done_q  <= dump_done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    cur_line_d   = cur_line_q;
    sec_d        = sec_q;
    remain_d     = remain_q;
    hold_d       = hold_q;
    abort_pend_d = abort_pend_q;
    dump_done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dump_start && !dump_abort) begin
          cur_line_d   = start_line_s;
          sec_d        = '0;
          remain_d     = line_cnt_s;
          abort_pend_d = 1'b0;
          if (line_cnt_s == '0) begin
            dump_done_d = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (dump_abort) begin
          state_d     = S_IDLE;
          dump_done_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // An abort here must still absorb the in-flight response before releasing the logger
        if (rd_resp_val) begin
          if (dump_abort || abort_pend_q) begin
            state_d      = S_IDLE;
            dump_done_d  = 1'b1;
            abort_pend_d = 1'b0;
          end else begin
            hold_d  = rd_resp_data;
            state_d = S_SEND;
          end
        end else if (dump_abort) begin
          abort_pend_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_SEND: begin
        if (dump_abort) begin
          state_d     = S_IDLE;
          dump_done_d = 1'b1;
        end else if (out_rdy) begin
          if (sec_q == SEC_LAST) begin
            sec_d      = '0;
            cur_line_d = cur_line_q + LINE_ADDR_W'(1);
            remain_d   = remain_q - CNT_ONE;
            if (remain_q == CNT_ONE) begin
              state_d     = S_IDLE;
              dump_done_d = 1'b1;
            end else begin
              state_d = S_REQ;
            end
          end else begin
            sec_d   = sec_q + SECTIONS_W'(1);
            state_d = S_REQ;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy           = (state_q != S_IDLE);
  assign logging_active = log_en & (state_q == S_IDLE);
  assign dump_done      = dump_done_q;
  assign rd_req_val     = (state_q == S_REQ);
  assign rd_req_addr    = {cur_line_q, sec_q, {ZERO_W{1'b0}}};
  assign out_val        = (state_q == S_SEND);
  assign out_data       = hold_q;
  assign out_last       = (state_q == S_SEND) && last_word_s;

endmodule

// File: tb/tb_mini_logger_dump_ctrl.sv
// Scoreboard bench for mini_logger_dump_ctrl with a behavioural logger read port and consumer.
module tb_mini_logger_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        log_en;
  logic        logging_active;
  logic        dump_start;
  logic        dump_abort;
  logic        busy;
  logic        dump_done;
  logic [12:0] curr_wr_addr;
  logic        has_looped;
  logic        rd_req_val;
  logic [12:0] rd_req_addr;
  logic        rd_resp_val;
  logic [63:0] rd_resp_data;
  logic        out_val;
  logic [63:0] out_data;
  logic        out_last;
  logic        out_rdy;

  mini_logger_dump_ctrl dut (
    .clk(clk), .rst(rst), .log_en(log_en), .logging_active(logging_active),
    .dump_start(dump_start), .dump_abort(dump_abort), .busy(busy), .dump_done(dump_done),
    .curr_wr_addr(curr_wr_addr), .has_looped(has_looped),
    .rd_req_val(rd_req_val), .rd_req_addr(rd_req_addr),
    .rd_resp_val(rd_resp_val), .rd_resp_data(rd_resp_data),
    .out_val(out_val), .out_data(out_data), .out_last(out_last), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [12:0] req_q[$];
  logic [63:0] data_q[$];
  logic        last_q[$];

  int  fixed_lat   = 0;
  int  lat_cnt     = 0;
  logic [12:0] pend_addr = '0;
  bit  rdy_low     = 1'b0;
  bit  rand_rdy    = 1'b0;
  int  stall_at    = -1;
  int  stall_cnt   = 0;
  int  out_cnt     = 0;
  int  done_cnt    = 0;
  bit  busy_seen   = 1'b0;
  bit  hold_chk_en = 1'b1;
  bit  prev_stall  = 1'b0;
  bit  prev_acc    = 1'b0;
  logic [63:0] prev_data = '0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] mdl_data(input logic [12:0] a);
    return {3'b101, a, 16'hBEEF, ~a, 19'h0};
  endfunction

  // Expected read order: oldest line first, sections 0..2 of each line
  task automatic push_expected(input int wr, input bit lp);
    int start;
    int n;
    start = lp ? wr : 0;
    n     = lp ? 256 : wr;
    for (int i = 0; i < n; i++) begin
      logic [7:0] ln;
      ln = 8'((start + i) % 256);
      for (int s = 0; s < 3; s++) begin
        logic [12:0] a;
        a = {ln, 2'(s), 3'b000};
        req_q.push_back(a);
        data_q.push_back(mdl_data(a));
        last_q.push_back((i == n - 1) && (s == 2));
      end
    end
  endtask

  // Logger read-port model and consumer ready driver
  always @(posedge clk) begin
    #1;
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        rd_resp_val  = 1'b1;
        rd_resp_data = mdl_data(pend_addr);
      end else begin
        rd_resp_val = 1'b0;
      end
    end else begin
      rd_resp_val = 1'b0;
    end
    if (rd_req_val) begin
      pend_addr = rd_req_addr;
      lat_cnt   = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
    end
    if (rdy_low) begin
      out_rdy = 1'b0;
    end else if (stall_cnt > 0) begin
      out_rdy = 1'b0;
      stall_cnt--;
    end else if (stall_at >= 0 && out_cnt == stall_at) begin
      out_rdy   = 1'b0;
      stall_cnt = 9;
      stall_at  = -1;
    end else begin
      out_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Output monitor and scoreboard compare
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_acc   = 1'b0;
    end else begin
      if (busy) begin
        busy_seen = 1'b1;
        check_val("log_gate", logging_active, 1'b0);
      end
      if (dump_done) done_cnt++;
      if (prev_stall) begin
        check_val("hold_val", out_val, 1'b1);
        check_val("hold_data", out_data, prev_data);
        check_val("hold_noreq", rd_req_val, 1'b0);
      end
      if (prev_acc) check_val("word_gap", out_val, 1'b0);
      if (rd_req_val) begin
        if (req_q.size() == 0) check_val("req_unexpected", rd_req_addr, 13'h1FFF ^ rd_req_addr);
        else check_val("req_addr", rd_req_addr, req_q.pop_front());
      end
      if (out_val && out_rdy) begin
        if (data_q.size() == 0) begin
          check_val("out_unexpected", out_data, ~out_data);
        end else begin
          check_val("out_data", out_data, data_q.pop_front());
          check_val("out_last", out_last, last_q.pop_front());
        end
        out_cnt++;
      end
      prev_stall = hold_chk_en && out_val && !out_rdy;
      prev_acc   = out_val && out_rdy;
      prev_data  = out_data;
    end
  end

  task automatic start_dump(input int wr, input bit lp, input bit ab);
    @(posedge clk); #2;
    curr_wr_addr = {8'(wr), 5'b00000};
    has_looped   = lp;
    dump_start   = 1'b1;
    dump_abort   = ab;
    @(posedge clk); #2;
    dump_start   = 1'b0;
    dump_abort   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int i;
    for (i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    check_val({tag, "_timeout"}, (done_cnt != d0), 1'b1);
    repeat (4) @(posedge clk);
    #2;
    check_val({tag, "_done_once"}, done_cnt - d0, 1);
    check_val({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic wait_out_val(input string tag);
    int i;
    for (i = 0; i < 200 && !out_val; i++) @(posedge clk);
    check_val({tag, "_outval_seen"}, out_val, 1'b1);
  endtask

  initial begin
    int d0;
    int o0;
    rst = 1'b1; log_en = 1'b1; dump_start = 1'b0; dump_abort = 1'b0;
    curr_wr_addr = '0; has_looped = 1'b0; rd_resp_val = 1'b0; rd_resp_data = '0; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", dump_done, 1'b0);
    check_val("rst_req", {rd_req_val, rd_req_addr}, 14'h0);
    check_val("rst_out", {out_val, out_last, out_data}, 66'h0);
    check_val("rst_logact", logging_active, 1'b1);
    rst = 1'b0;

    // Empty log
    busy_seen = 1'b0; d0 = done_cnt;
    start_dump(0, 1'b0, 1'b0);
    wait_done("empty", d0, 10);
    check_val("empty_busy", busy_seen, 1'b0);

    // Partial log, three lines, fixed latency
    fixed_lat = 1; d0 = done_cnt; o0 = out_cnt;
    push_expected(3, 1'b0);
    start_dump(3, 1'b0, 1'b0);
    wait_done("partial", d0, 500);
    check_val("partial_words", out_cnt - o0, 9);
    check_val("partial_q", req_q.size() + data_q.size(), 0);

    // Backpressure: 10-cycle stall mid-dump
    fixed_lat = 2; d0 = done_cnt; o0 = out_cnt; stall_at = out_cnt + 4;
    push_expected(2, 1'b0);
    start_dump(2, 1'b0, 1'b0);
    wait_done("bp", d0, 500);
    check_val("bp_words", out_cnt - o0, 6);

    // Wrapped log: 256 lines from line 5, random latency and ready
    fixed_lat = 0; rand_rdy = 1'b1; d0 = done_cnt; o0 = out_cnt;
    push_expected(5, 1'b1);
    start_dump(5, 1'b1, 1'b0);
    wait_done("wrap", d0, 20000);
    check_val("wrap_words", out_cnt - o0, 768);
    check_val("wrap_q", req_q.size() + data_q.size(), 0);
    rand_rdy = 1'b0;

    // Abort while waiting on the logger response
    fixed_lat = 3; d0 = done_cnt; o0 = out_cnt;
    req_q.push_back(13'h0);
    start_dump(3, 1'b0, 1'b0);
    #1;
    check_val("abw_req_phase", rd_req_val, 1'b1);
    @(posedge clk); #2;
    dump_abort = 1'b1;
    @(posedge clk); #2;
    dump_abort = 1'b0;
    check_val("abw_still_busy", busy, 1'b1);
    wait_done("abw", d0, 50);
    check_val("abw_words", out_cnt - o0, 0);
    check_val("abw_q", req_q.size(), 0);

    // Abort during SEND with consumer stalled
    fixed_lat = 1; rdy_low = 1'b1; hold_chk_en = 1'b0; d0 = done_cnt;
    req_q.push_back(13'h0);
    start_dump(4, 1'b0, 1'b0);
    wait_out_val("abs");
    #2;
    dump_abort = 1'b1;
    @(posedge clk); #2;
    dump_abort = 1'b0;
    check_val("abs_outval_drop", out_val, 1'b0);
    wait_done("abs", d0, 20);
    rdy_low = 1'b0; hold_chk_en = 1'b1;

    // Start and abort together in IDLE: start ignored
    busy_seen = 1'b0; d0 = done_cnt;
    start_dump(3, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    check_val("sa_busy", busy_seen, 1'b0);
    check_val("sa_done", done_cnt - d0, 0);

    // Async reset in the middle of SEND
    rdy_low = 1'b1; hold_chk_en = 1'b0;
    req_q.push_back(13'h0);
    start_dump(2, 1'b0, 1'b0);
    wait_out_val("rst");
    #2;
    check_val("rst_pre_logact", logging_active, 1'b0);
    rst = 1'b1;
    #1;
    check_val("arst_outval", {out_val, out_last}, 2'b00);
    check_val("arst_data", out_data, 64'h0);
    check_val("arst_busy", {busy, rd_req_val, dump_done}, 3'b000);
    check_val("arst_logact", logging_active, 1'b1);
    @(posedge clk); #2;
    rst = 1'b0; lat_cnt = 0; rdy_low = 1'b0; hold_chk_en = 1'b1;
    req_q.delete(); data_q.delete(); last_q.delete();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
